// File: rtl/alpha_startup_sequencer.sv
// ============================================================================
//  Module      : alpha_startup_sequencer
//  Description : Ordered chain of NUM_STAGES startup stages with a per-stage
//                enable, a 2^pickoff hold-off, optional trigger on the last
//                stage, and rearm/abort control.
//                Macro ALPHA_STARTUP_SEQUENCER_FAST_SIM_EN caps the pickoff at 3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alpha_startup_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int DELAY_PICKOFF = 26,
    parameter int TRIGGER_LAST  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_STAGES-1:0]         stage_enable,
    input  logic                          trigger,
    input  logic                          rearm,
    input  logic                          abort,
    output logic [NUM_STAGES-1:0]         stage_pulse,
    output logic [NUM_STAGES-1:0]         stage_done,
    output logic [$clog2(NUM_STAGES)-1:0] current_stage,
    output logic                          armed,
    output logic                          busy,
    output logic                          done
);

    localparam int SW = $clog2(NUM_STAGES);
`ifdef ALPHA_STARTUP_SEQUENCER_FAST_SIM_EN
    localparam int PICK = (DELAY_PICKOFF < 3) ? DELAY_PICKOFF : 3;
`else
    localparam int PICK = DELAY_PICKOFF;
`endif
    localparam int CW = PICK + 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);

    localparam logic [2:0] ST_WAIT = 3'd0;
    localparam logic [2:0] ST_SKIP = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_FIRE = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    logic [2:0]            r_state, w_state;
    logic [SW-1:0]         r_stage, w_stage;
    logic [CW-1:0]         r_count, w_count;
    logic [NUM_STAGES-1:0] r_done_flags, w_done_flags;
    logic                  r_entry;
    logic                  w_last;
    logic                  w_active;
    logic [SW-1:0]         w_stage_inc;

    // Decision taken on the edge that enters a stage.
    function automatic logic [2:0] f_entry(input logic en, input logic is_last);
        if (!en)
            return ST_SKIP;
        if (is_last && (TRIGGER_LAST != 0))
            return ST_ARM;
        return ST_WAIT;
    endfunction

    assign w_last      = (r_stage == LAST);
    assign w_stage_inc = r_stage + SW'(1);
    assign w_active    = (r_state == ST_WAIT) || (r_state == ST_SKIP) ||
                         (r_state == ST_ARM)  || (r_state == ST_FIRE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_WAIT;
            r_stage      <= '0;
            r_count      <= '0;
            r_done_flags <= '0;
            r_entry      <= 1'b1;
        end else begin
            r_state      <= w_state;
            r_stage      <= w_stage;
            r_count      <= w_count;
            r_done_flags <= w_done_flags;
            r_entry      <= 1'b0;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_stage      = r_stage;
        w_count      = r_count;
        w_done_flags = r_done_flags;
        // abort beats rearm even when the abort alone would be ignored
        if (abort && (rearm || w_active)) begin
            w_state = ST_HALT;
        end else if (rearm) begin
            w_done_flags = '0;
            w_stage      = '0;
            w_count      = '0;
            w_state      = f_entry(stage_enable[0], NUM_STAGES == 1);
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (r_entry) begin
                        w_state = f_entry(stage_enable[r_stage], w_last);
                        w_count = '0;
                    end else if (r_count[PICK]) begin
                        w_state               = ST_FIRE;
                        w_count               = '0;
                        w_done_flags[r_stage] = 1'b1;
                    end else begin
                        w_count = r_count + CW'(1);
                    end
                end
                ST_ARM: begin
                    if (trigger) begin
                        w_state               = ST_FIRE;
                        w_done_flags[r_stage] = 1'b1;
                    end
                end
                ST_FIRE, ST_SKIP: begin
                    w_count = '0;
                    if (w_last) begin
                        w_state = ST_DONE;
                    end else begin
                        w_stage = w_stage_inc;
                        w_state = f_entry(stage_enable[w_stage_inc], w_stage_inc == LAST);
                    end
                end
                ST_DONE, ST_HALT: ;
                default: w_state = ST_HALT;
            endcase
        end
    end

    always_comb begin
        stage_pulse = '0;
        if (r_state == ST_FIRE)
            stage_pulse[r_stage] = 1'b1;
        armed = (r_state == ST_ARM);
        busy  = w_active;
        done  = (r_state == ST_DONE);
    end

    assign stage_done    = r_done_flags;
    assign current_stage = r_stage;

endmodule

`default_nettype wire

// File: doc/alpha_startup_sequencer.md
# alpha_startup_sequencer

Parametrised startup sequencer for ALPHA eval-board bring-up. It generalises the fixed chain "startup sequence 3, then 2, then i2c transfer, then 1 on button" into a chain of NUM_STAGES ordered stages. Each stage has a runtime enable, a power-of-two hold-off delay, and a one-cycle fire pulse. The last stage can optionally wait for an external trigger such as a debounced button. The block sits between the board top level and alpha_control, and adds rearm, abort and status outputs.

## Interface
- NUM_STAGES, 4: number of stages, 2..16; stage 0 fires first.
- DELAY_PICKOFF, 26: hold-off counter bit; the delay per stage is 2^DELAY_PICKOFF cycles; range 2..30.
- TRIGGER_LAST, 1: 1 means stage NUM_STAGES-1 waits for `trigger` instead of the delay; 0 means it uses the delay like every other stage.
- SW = $clog2(NUM_STAGES): width of `current_stage` (derived, not user-set).

- clock  input  1  system clock (sysclk domain).
- reset  input  1  synchronous, active-low reset; reset==0 on a rising edge resets the block.
- stage_enable  input  NUM_STAGES  per-stage enable; bit k is sampled on the cycle stage k is entered.
- trigger  input  1  single-cycle pulse that releases the last stage when TRIGGER_LAST=1.
- rearm  input  1  single-cycle pulse that restarts the chain from stage 0.
- abort  input  1  single-cycle pulse that halts the chain.
- stage_pulse  output  NUM_STAGES  one-cycle fire strobe per stage; wire it to the alpha_control start inputs.
- stage_done  output  NUM_STAGES  sticky flag per stage, set when that stage fires.
- current_stage  output  SW  index of the stage being processed.
- armed  output  1  high while waiting for `trigger`.
- busy  output  1  high in WAIT, SKIP, ARM or FIRE.
- done  output  1  high in DONE.

## Operation
- FSM states: WAIT, SKIP, ARM, FIRE, DONE, HALT.
- Reset (reset==0): state WAIT, current_stage=0, counter=0, stage_pulse=0, stage_done=0, armed=0, busy=1, done=0. The chain starts by itself on the first cycle after reset is released.
- Stage entry: stage_enable[current_stage] is sampled on the entry cycle.
  - Enable bit 0: go to SKIP.
  - Enable bit 1, stage is last, TRIGGER_LAST=1: go to ARM.
  - Otherwise: stay in WAIT with counter=0.
- WAIT: the counter increments every cycle. When counter[DELAY_PICKOFF]==1, go to FIRE.
- ARM: armed=1. When trigger==1, go to FIRE.
- FIRE: lasts one cycle.
  - stage_pulse[current_stage]=1 and stage_done[current_stage] is set.
  - Counter clears to 0.
  - If current_stage is the last stage, go to DONE. Otherwise increment current_stage and enter the next stage.
- SKIP: lasts one cycle. No pulse, and stage_done is unchanged. Then advance exactly as FIRE does.
- DONE: holds until rearm or reset. current_stage holds the last index.
- HALT: no pulses are issued; stage_done and current_stage hold their values. busy=0 and done=0.
- abort: from WAIT, SKIP, ARM or FIRE, go to HALT on the next cycle. A FIRE cycle that is already in progress still completes its pulse. abort in DONE or HALT is ignored.
- rearm: from any state, clear stage_done, set counter=0 and current_stage=0, then enter stage 0.
- rearm and abort in the same cycle: abort wins.
- trigger outside ARM is ignored and is not latched.
- Pulses are one-hot: at most one stage_pulse bit is high in any cycle.

## Timing
- Cycle 0 is the first rising edge with reset==1.
- Enabled delayed stage entered at cycle t: its pulse is high at cycle t+2^DELAY_PICKOFF+1, and the next stage is entered at the following cycle.
- Skipped stage: costs 1 cycle.
- ARM: the pulse is high in the cycle after the trigger is sampled high.
- All outputs are registered, with no combinational path from input to output.
- Counter width is DELAY_PICKOFF+1 bits and never wraps; it is cleared in FIRE, SKIP, on rearm and on reset.

## Configuration
- Macro ALPHA_STARTUP_SEQUENCER_FAST_SIM_EN.
  - Defined: the effective pickoff is min(DELAY_PICKOFF, 3), so each stage delay is 8 cycles, for simulation and bench runs.
  - Undefined: DELAY_PICKOFF is used unchanged (synthesis default).

## Test plan
All scenarios use FAST_SIM_EN, NUM_STAGES=4 and TRIGGER_LAST=1.
- Release reset with stage_enable=4'b1111 → stage_pulse[0] at cycle 9, stage_pulse[1] at 19, stage_pulse[2] at 29; armed=1 from cycle 30. Trigger at cycle 50 → stage_pulse[3] at 51, done=1 at 52, stage_done=4'b1111.
- stage_enable=4'b1010 → no pulse for stages 0 and 2. stage_pulse[1] at cycle 10, and armed rises after the stage-2 skip. Final stage_done=4'b1010 after trigger.
- stage_enable=4'b0000 → done=1 at cycle 4, no pulses ever, and trigger is ignored.
- Trigger pulse at cycle 5 (before ARM) → no effect. The last stage still waits for a later trigger.
- abort at cycle 12 → state HALT with stage_done=4'b0001 held, no further pulses. Then rearm → stage_done clears and stage_pulse[0] fires 9 cycles after the rearm cycle.
- reset driven to 0 at cycle 15 mid-WAIT → all outputs take their reset values on the next cycle. After release the sequence restarts, and abort together with rearm in one cycle results in HALT.
